// File: rtl/mesh_router_param.sv
// Five-port XY mesh router: per-input FIFOs, per-output round-robin arbiters
// and registered output slots, so every output can move one packet per cycle.
module mesh_router_param #(
  parameter int unsigned PL    = 32,
  parameter int unsigned CS    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CS-1:0]   router_X,
  input  logic [CS-1:0]   router_Y,
  input  logic [5*PL-1:0] in_data,
  input  logic [4:0]      in_valid,
  output logic [4:0]      in_ready,
  output logic [5*PL-1:0] out_data,
  output logic [4:0]      out_valid,
  input  logic [4:0]      out_ready
);
  localparam int unsigned NP = 5;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] P_L = 3'd0;
  localparam logic [2:0] P_N = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_S = 3'd3;
  localparam logic [2:0] P_W = 3'd4;

  logic [PL-1:0] mem_q   [NP][DEPTH];
  logic [AW-1:0] wptr_q  [NP];
  logic [AW-1:0] rptr_q  [NP];
  logic [CW-1:0] cnt_q   [NP];
  logic [PL-1:0] head    [NP];
  logic [2:0]    route   [NP];
  logic [NP-1:0] nonempty;
  logic [NP-1:0] push;
  logic [NP-1:0] pop;

  logic [2:0]    ptr_q   [NP];
  logic [2:0]    ptr_d   [NP];
  logic [NP-1:0] ov_q;
  logic [NP-1:0] ov_d;
  logic [PL-1:0] od_q    [NP];
  logic [PL-1:0] od_d    [NP];

  function automatic logic [2:0] xy_route(input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                                          input logic [CS-1:0] rx, input logic [CS-1:0] ry);
    if (dx > rx)      return P_E;
    else if (dx < rx) return P_W;
    else if (dy > ry) return P_N;
    else if (dy < ry) return P_S;
    else              return P_L;
  endfunction

  // (base + off) mod 5 for base, off in 0..4
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Ready is gated by reset so it reads low while rst_n is held.
  always_comb begin
    for (int i = 0; i < int'(NP); i++) begin
      in_ready[i] = rst_n && (cnt_q[i] != CW'(DEPTH));
    end
  end

  assign push = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < int'(NP); i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      head[i]     = mem_q[i][rptr_q[i]];
      route[i]    = xy_route(head[i][PL-1 -: CS], head[i][PL-1-CS -: CS], router_X, router_Y);
    end
  end

  // Per-output arbitration; descending scan lets the highest-priority requester win.
  always_comb begin
    logic [2:0] idx;
    logic [2:0] gi;
    logic       gv;
    pop = '0;
    idx = '0;
    gi  = '0;
    gv  = 1'b0;
    for (int o = 0; o < int'(NP); o++) begin
      ptr_d[o] = ptr_q[o];
      ov_d[o]  = ov_q[o];
      od_d[o]  = od_q[o];
      gv       = 1'b0;
      gi       = '0;
      if (!ov_q[o] || out_ready[o]) begin
        ov_d[o] = 1'b0;
        for (int k = int'(NP) - 1; k >= 0; k--) begin
          idx = rr_idx(ptr_q[o], 3'(k));
          if (nonempty[idx] && (route[idx] == 3'(o))) begin
            gv = 1'b1;
            gi = idx;
          end
        end
        if (gv) begin
          pop[gi]  = 1'b1;
          ov_d[o]  = 1'b1;
          od_d[o]  = head[gi];
          ptr_d[o] = rr_idx(gi, 3'd1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NP); i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        ptr_q[i]  <= '0;
        od_q[i]   <= '0;
      end
      ov_q <= '0;
    end else begin
      for (int i = 0; i < int'(NP); i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        ptr_q[i] <= ptr_d[i];
        od_q[i]  <= od_d[i];
      end
      ov_q <= ov_d;
    end
  end

  // FIFO storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NP); i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_data[i*PL +: PL];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NP); i++) begin
      out_data[i*PL +: PL] = od_q[i];
    end
  end

  assign out_valid = ov_q;

endmodule

// File: tb/tb_mesh_router_param.sv
// Directed self-checking bench for mesh_router_param at node (1,1), default parameters.
module tb_mesh_router_param;
  localparam int unsigned PL = 32;
  localparam int unsigned CS = 2;
  localparam int unsigned DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic [CS-1:0]   router_X;
  logic [CS-1:0]   router_Y;
  logic [5*PL-1:0] in_data;
  logic [4:0]      in_valid;
  logic [4:0]      in_ready;
  logic [5*PL-1:0] out_data;
  logic [4:0]      out_valid;
  logic [4:0]      out_ready;

  int n_checks;
  int n_errors;

  mesh_router_param #(.PL(PL), .CS(CS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .router_X  (router_X),
    .router_Y  (router_Y),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [31:0] pkt(input logic [1:0] dx, input logic [1:0] dy, input logic [27:0] pl);
    return {dx, dy, pl};
  endfunction

  function automatic logic [31:0] cpkt(input int src, input int seq);
    return pkt(2'd1, 2'd1, 28'(src * 256 + seq));
  endfunction

  function automatic logic [31:0] qpkt(input int seq);
    return pkt(2'd2, 2'd1, 28'(32'hB00 + seq));
  endfunction

  logic [31:0] xy_pkt [5];
  int          xy_out [5];
  int          seq    [5];
  logic [4:0]  acc;
  int          g;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    router_X  = 2'd1;
    router_Y  = 2'd1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 5'b11111;

    // Reset state, then release
    #1;
    check("rst_in_ready", 160'(in_ready), 160'(5'b00000));
    check("rst_out_valid", 160'(out_valid), 160'(5'b00000));
    check("rst_out_data", 160'(out_data), 160'(0));
    #5;
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 160'(in_ready), 160'(5'b11111));
    check("post_rst_out_valid", 160'(out_valid), 160'(5'b00000));

    // XY routing from the Local port
    xy_pkt[0] = pkt(2'd2, 2'd1, 28'h0000A01); xy_out[0] = 2;
    xy_pkt[1] = pkt(2'd0, 2'd1, 28'h0000A02); xy_out[1] = 4;
    xy_pkt[2] = pkt(2'd1, 2'd2, 28'h0000A03); xy_out[2] = 1;
    xy_pkt[3] = pkt(2'd1, 2'd0, 28'h0000A04); xy_out[3] = 3;
    xy_pkt[4] = pkt(2'd1, 2'd1, 28'h0000A05); xy_out[4] = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        in_valid[0] = 1'b1;
        in_data[0 +: 32] = xy_pkt[i];
      end else begin
        in_valid[0] = 1'b0;
      end
      step();
      if (i > 0) begin
        check($sformatf("xy_valid_%0d", i - 1), 160'(out_valid), 160'(5'b00001 << xy_out[i-1]));
        check($sformatf("xy_data_%0d", i - 1), 160'(out_data[xy_out[i-1]*32 +: 32]), 160'(xy_pkt[i-1]));
      end
    end

    // Five inputs contend for the Local output
    do_reset();
    for (int i = 0; i < 5; i++) begin
      seq[i] = 0;
      in_valid[i] = 1'b1;
      in_data[i*32 +: 32] = cpkt(i, 0);
    end
    for (int c = 1; c <= 12; c++) begin
      acc = in_valid & in_ready;
      step();
      for (int i = 0; i < 5; i++) begin
        if (acc[i]) seq[i]++;
        in_data[i*32 +: 32] = cpkt(i, seq[i]);
      end
      if (c >= 2) begin
        g = c - 2;
        check($sformatf("rr_grant_%0d", g), {127'(0), out_valid[0], out_data[31:0]},
              {127'(0), 1'b1, cpkt(g % 5, g / 5)});
      end
    end

    // Asynchronous reset mid-traffic
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 160'(out_valid), 160'(5'b00000));
    check("midrst_out_data", 160'(out_data), 160'(0));
    check("midrst_in_ready", 160'(in_ready), 160'(5'b00000));
    in_valid = '0;
    #2;
    rst_n = 1'b1;
    step();
    check("midrst_rel_in_ready", 160'(in_ready), 160'(5'b11111));
    check("midrst_rel_out_valid", 160'(out_valid), 160'(5'b00000));

    // Four packets cross the node in parallel
    do_reset();
    in_data[1*32 +: 32] = pkt(2'd1, 2'd0, 28'h0000C01);
    in_data[3*32 +: 32] = pkt(2'd1, 2'd2, 28'h0000C03);
    in_data[2*32 +: 32] = pkt(2'd0, 2'd1, 28'h0000C02);
    in_data[4*32 +: 32] = pkt(2'd2, 2'd1, 28'h0000C04);
    in_valid = 5'b11110;
    step();
    in_valid = '0;
    step();
    check("par_valid", 160'(out_valid), 160'(5'b11110));
    check("par_south", 160'(out_data[3*32 +: 32]), 160'(pkt(2'd1, 2'd0, 28'h0000C01)));
    check("par_north", 160'(out_data[1*32 +: 32]), 160'(pkt(2'd1, 2'd2, 28'h0000C03)));
    check("par_west", 160'(out_data[4*32 +: 32]), 160'(pkt(2'd0, 2'd1, 28'h0000C02)));
    check("par_east", 160'(out_data[2*32 +: 32]), 160'(pkt(2'd2, 2'd1, 28'h0000C04)));

    // Backpressure on East fills the Local FIFO
    do_reset();
    out_ready = 5'b11011;
    seq[0] = 0;
    in_valid[0] = 1'b1;
    in_data[0 +: 32] = qpkt(0);
    for (int c = 1; c <= 8; c++) begin
      acc = in_valid & in_ready;
      step();
      if (acc[0]) seq[0]++;
      in_data[0 +: 32] = qpkt(seq[0]);
      if (c == 4) check("bp_ready_before_full", 160'(in_ready[0]), 160'(1'b1));
      if (c == 5) check("bp_ready_at_full", 160'(in_ready[0]), 160'(1'b0));
    end
    check("bp_accepted", 160'(seq[0]), 160'(5));
    check("bp_slot_held", {127'(0), out_valid[2], out_data[2*32 +: 32]}, {127'(0), 1'b1, qpkt(0)});

    // Release: full FIFO pops but rejects the waiting push that cycle
    out_ready = 5'b11111;
    for (int j = 1; j <= 6; j++) begin
      acc = in_valid & in_ready;
      step();
      if (acc[0]) seq[0]++;
      in_data[0 +: 32] = qpkt(seq[0]);
      if (seq[0] == 6) in_valid[0] = 1'b0;
      if (j == 1) begin
        check("full_push_rejected", 160'(seq[0]), 160'(5));
        check("full_ready_back", 160'(in_ready[0]), 160'(1'b1));
      end
      if (j <= 5)
        check($sformatf("drain_%0d", j), {127'(0), out_valid[2], out_data[2*32 +: 32]},
              {127'(0), 1'b1, qpkt(j)});
      else
        check("drain_empty", 160'(out_valid), 160'(5'b00000));
    end
    check("full_push_late_accept", 160'(seq[0]), 160'(6));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mesh_router_param.md
# mesh_router_param

Parametrised five-port mesh router, the next generation of the 3x3 mesh router. Each input port has its own FIFO of configurable depth and width. XY routing is computed per input head. Each output port has an independent round-robin arbiter and a registered output slot, so up to five packets move per cycle instead of one. It sits at every mesh node, between the node's local core interface and its four neighbours.

## Interface
Parameters:
- PL, 32: packet width in bits; header = dest X at [PL-1 -: CS], dest Y at [PL-1-CS -: CS], payload below.
- CS, 2: coordinate width in bits.
- DEPTH, 4: entries per input FIFO; power of two, ≥2.

Ports (index p = 0 Local, 1 North, 2 East, 3 South, 4 West; packet for port p at [p*PL +: PL]):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- router_X  in  CS  this node's X coordinate; static after reset.
- router_Y  in  CS  this node's Y coordinate; static after reset.
- in_data  in  5*PL  inbound packets.
- in_valid  in  5  inbound packet present.
- in_ready  out  5  input FIFO not full.
- out_data  out  5*PL  outbound packets.
- out_valid  out  5  output slot holds a packet.
- out_ready  in  5  downstream accepts.

## Operation
- Transfer on any port = valid & ready at a rising clk edge. A sender must hold data stable while valid is high and ready is low.
- Input FIFO: circular buffer with read/write pointers and a count of $clog2(DEPTH)+1 bits. Push on in_valid&in_ready. in_ready = (count != DEPTH); a full FIFO rejects even when popping in the same cycle. There is no bypass: a pushed packet is first visible at the head on the next cycle.
- Route of a non-empty FIFO head, unsigned compare:
  - dX > router_X → East.
  - dX < router_X → West.
  - Otherwise dY > router_Y → North.
  - Otherwise dY < router_Y → South.
  - Otherwise → Local.
- Each input requests exactly one output: its head's route. U-turns are routed without any check.
- Per output o:
  - The slot is free if !out_valid[o], or out_valid[o]&out_ready[o] in this cycle.
  - If the slot is free and there are requesters, the round-robin arbiter grants one input. The granted FIFO pops and out_data[o] loads its head at the edge.
  - If the slot is freed with no requester, out_valid[o] clears.
  - If the slot is not free, no grant is given and out_data[o] holds.
- Round-robin: each output has a 3-bit pointer ptr[o] in the range 0..4; input ptr[o] has highest priority, then ascending order modulo 5. After a grant to input i, ptr[o] ← (i+1) mod 5. The pointer is unchanged when no grant is given.
- Distinct outputs arbitrate independently. An input can win at most one output per cycle, because it requests only one.
- Reset (asynchronous, any time, including mid-transfer):
  - All FIFOs empty, all pointers and ptr[o] = 0.
  - out_valid = 0, out_data = 0, in_ready = 0 while rst_n is low.
  - In-flight packets are discarded.
  - in_ready = 1 on the first cycle after rst_n rises.

## Timing
- Latency: a packet pushed at edge k into an empty FIFO with a free destination slot shows out_valid at edge k+1. That is 2 edges from acceptance to first output presentation.
- Throughput: 1 packet per cycle per output with out_ready held high. Aggregate is up to 5 per cycle.
- Backpressure: out_ready low holds out_valid/out_data unchanged. The FIFO fills, and in_ready drops on the edge where count reaches DEPTH.
- Fairness: N inputs continuously contending for one output are each granted exactly once in every N consecutive grants.
- All outputs are registered, with no combinational path from in_valid to out_valid. in_ready depends only on registered count.

## Test plan
- Reset/idle: assert rst_n low mid-traffic → out_valid=0, out_data=0, in_ready=0 immediately. After release → in_ready=5'b11111, out_valid=0.
- XY routing, node (1,1), CS=2: inject on Local one packet each to (2,1), (0,1), (1,2), (1,0), (1,1) → the packets exit in that order on East, West, North, South, Local, each 2 edges after its acceptance.
- Contention/fairness: Local, North, East, South and West all stream packets to dest (1,1) with out_ready[0]=1 → Local output grants in order 0,1,2,3,4,0,…, and no input wins twice within 5 grants.
- Parallelism: at node (1,1), inputs N→(1,0), S→(1,2), E→(0,1), W→(2,1) in the same cycle → all four appear on out_valid at the same edge.
- Backpressure/full: out_ready[2]=0, DEPTH=4, Local floods East → 1 packet held in the slot. in_ready[0] falls after 4 more are accepted. Raising out_ready delivers all 5 in order, with no loss or duplication.
- Push while full: with FIFO full and a pop occurring in the same cycle, hold in_valid=1 → the packet is not accepted that cycle. It is accepted the next cycle once in_ready=1.
